ahb_lite_master_bridge: RTL and testbench

- Converts a simple processor-style request/acknowledge port into single AHB-Lite master transfers.
- Sits directly upstream of the system AHB-Lite slaves (RAM with wait states, SDRAM controller) and drives their HADDR/HTRANS/HWRITE/HWDATA.
- Honours slave HREADY wait states in both address and data phases, and returns read data and an error flag to the requester.

---
 rtl/ahb_lite_master_bridge_if.sv | 42 ++++
 rtl/ahb_lite_master_bridge.sv | 134 +++++++++++++
 tb/tb_ahb_lite_master_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_bridge_if.sv
// Request/ack port and AHB-Lite master bus bundle for ahb_lite_master_bridge.
// master: bridge view; slave: requester plus AHB slave view.
interface ahb_lite_master_bridge_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req;
   logic                  req_write;
   logic [1:0]            req_size;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  ack;
   logic                  err;
   logic [31:0]           rdata;

   logic [31:0]           HADDR;
   logic [2:0]            HBURST;
   logic                  HMASTLOCK;
   logic [3:0]            HPROT;
   logic [2:0]            HSIZE;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [31:0]           HWDATA;
   logic [31:0]           HRDATA;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      input  req, req_write, req_size, req_addr, req_wdata,
      output ack, err, rdata,
      output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE,
      output HTRANS, HWRITE, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      output req, req_write, req_size, req_addr, req_wdata,
      input  ack, err, rdata,
      input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE,
      input  HTRANS, HWRITE, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_lite_master_bridge.sv
// Native req/ack to single AHB-Lite transfers, one outstanding at a time.
// Define AHB_MASTER_BRIDGE_ERR_EN to report slave ERROR responses on err.
module ahb_lite_master_bridge #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic HCLK,
   input  logic HRESET,
   ahb_lite_master_bridge_if.master bus
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA
   } state_t;

   state_t      state_q;
   logic [31:0] haddr_q;
   logic [2:0]  hsize_q;
   logic [1:0]  htrans_q;
   logic        hwrite_q;
   logic [31:0] hwdata_q;
   logic [31:0] wdata_q;
   logic        ack_q;
   logic        err_q;
   logic [31:0] rdata_q;
`ifdef AHB_MASTER_BRIDGE_ERR_EN
   logic        errseen_q;
`endif

   logic        misal_d;
   logic [31:0] addr_d;

   assign addr_d = 32'(bus.req_addr);

   // Alignment check on the live request, used only on the sampling edge
   always_comb begin
      misal_d = 1'b0;
      unique case (bus.req_size)
         2'd0:    misal_d = 1'b0;
         2'd1:    misal_d = bus.req_addr[0];
         2'd2:    misal_d = |bus.req_addr[1:0];
         default: misal_d = 1'b1;
      endcase
   end

   // Transfer FSM; every bus and requester output is a register here
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= S_IDLE;
         haddr_q   <= '0;
         hsize_q   <= '0;
         htrans_q  <= TR_IDLE;
         hwrite_q  <= 1'b0;
         hwdata_q  <= '0;
         wdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
`ifdef AHB_MASTER_BRIDGE_ERR_EN
         errseen_q <= 1'b0;
`endif
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               // ack_q high means req is the old request still held
               if (bus.req && !ack_q) begin
                  wdata_q <= bus.req_wdata;
                  if (misal_d) begin
                     ack_q <= 1'b1;
                     err_q <= 1'b1;
                  end else begin
                     htrans_q <= TR_NONSEQ;
                     haddr_q  <= addr_d;
                     hwrite_q <= bus.req_write;
                     hsize_q  <= {1'b0, bus.req_size};
                     state_q  <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (bus.HREADY) begin
                  htrans_q <= TR_IDLE;
                  if (hwrite_q) hwdata_q <= wdata_q;
`ifdef AHB_MASTER_BRIDGE_ERR_EN
                  errseen_q <= 1'b0;
`endif
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
`ifdef AHB_MASTER_BRIDGE_ERR_EN
               if (!bus.HREADY && bus.HRESP) errseen_q <= 1'b1;
               if (bus.HREADY) begin
                  ack_q   <= 1'b1;
                  state_q <= S_IDLE;
                  if (errseen_q) begin
                     err_q <= 1'b1;
                  end else begin
                     err_q <= 1'b0;
                     if (!hwrite_q) rdata_q <= bus.HRDATA;
                  end
               end
`else
               if (bus.HREADY) begin
                  ack_q   <= 1'b1;
                  err_q   <= 1'b0;
                  state_q <= S_IDLE;
                  if (!hwrite_q) rdata_q <= bus.HRDATA;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.HADDR     = haddr_q;
   assign bus.HBURST    = 3'b000;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.HPROT     = 4'b0011;
   assign bus.HSIZE     = hsize_q;
   assign bus.HTRANS    = htrans_q;
   assign bus.HWRITE    = hwrite_q;
   assign bus.HWDATA    = hwdata_q;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench for ahb_lite_master_bridge with a wait-state slave model
// and an expected-response queue popped on each ack.
module tb_ahb_lite_master_bridge;

`ifdef AHB_MASTER_BRIDGE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic HCLK = 1'b0;
   logic HRESET;
   int   checks = 0;
   int   errors = 0;

   ahb_lite_master_bridge_if #(.ADDR_WIDTH(32)) bus ();

   ahb_lite_master_bridge #(.ADDR_WIDTH(32)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus.master)
   );

   always #5 HCLK = ~HCLK;

   // ---------------- slave model ----------------
   int          addr_waits = 0;
   int          data_waits = 0;
   bit          err_inject = 0;
   int          accepts    = 0;
   logic [31:0] smem [0:63];
   int          sph  = 0;
   int          acnt = 0;
   int          dcnt = 0;
   logic        s_wr;
   logic [5:0]  s_idx;

   // Decide HREADY/HRESP/HRDATA for the coming rising edge
   always @(negedge HCLK) begin
      if (HRESET) begin
         sph = 0; acnt = 0; dcnt = 0;
         bus.HREADY = 1'b1; bus.HRESP = 1'b0;
         bus.HRDATA = 32'h5A5A5A5A;
      end else if (sph == 0) begin
         bus.HRESP  = 1'b0;
         bus.HRDATA = 32'h5A5A5A5A;
         if (bus.HTRANS == 2'b10) begin
            if (acnt < addr_waits) begin
               bus.HREADY = 1'b0; acnt++;
            end else begin
               bus.HREADY = 1'b1; acnt = 0; dcnt = 0;
               accepts++;
               s_wr = bus.HWRITE; s_idx = bus.HADDR[7:2];
               sph = 1;
            end
         end else begin
            bus.HREADY = 1'b1;
         end
      end else begin
         if (err_inject) begin
            if (dcnt == 0) begin
               bus.HREADY = 1'b0; bus.HRESP = 1'b1; dcnt = 1;
            end else begin
               bus.HREADY = 1'b1; bus.HRESP = 1'b1; sph = 0;
            end
         end else if (dcnt < data_waits) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b0; dcnt++;
         end else begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            if (s_wr) smem[s_idx] = bus.HWDATA;
            else      bus.HRDATA = smem[s_idx];
            sph = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] ref_mem [0:63];
   logic [31:0] last_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      bit   mis;
      bit   berr;
      mis  = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
             (sz == 2'd2 && a[1:0] != 2'b00);
      berr = !mis && err_inject;
      e.err   = mis || (berr && ERR_EN);
      e.rdata = last_rdata;
      if (!mis && !berr) begin
         if (w) ref_mem[a[7:2]] = d;
         else   e.rdata = ref_mem[a[7:2]];
      end
      last_rdata = e.rdata;
      sb.push_back(e);
   endtask

   // One request; returns cycle counts seen from the first edge after drive
   task automatic xfer(input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit keep_req, output int ack_cyc,
                       output int ns_first, output int ns_cnt,
                       output int unstable, output int hwd_bad);
      logic [31:0] a0;
      exp_t        e;
      ack_cyc = 0; ns_first = 0; ns_cnt = 0; unstable = 0; hwd_bad = 0;
      a0 = '0;
      push_exp(w, sz, a, d);
      @(negedge HCLK);
      bus.req = 1'b1; bus.req_write = w; bus.req_size = sz;
      bus.req_addr = a; bus.req_wdata = d;
      for (int c = 1; c <= 60; c++) begin
         @(posedge HCLK); #1;
         if (bus.HTRANS == 2'b10) begin
            if (ns_cnt == 0) begin
               ns_first = c; a0 = bus.HADDR;
            end else if (bus.HADDR !== a0 || bus.HWRITE !== w) begin
               unstable++;
            end
            ns_cnt++;
         end else if (ns_cnt > 0 && !bus.ack && w && bus.HWDATA !== d) begin
            hwd_bad++;
         end
         if (bus.ack === 1'b1) begin
            ack_cyc = c;
            break;
         end
      end
      chk("ack_seen", 32'(ack_cyc != 0), 32'd1);
      if (ack_cyc != 0 && sb.size() > 0) begin
         e = sb.pop_front();
         chk("err", 32'(bus.err), 32'(e.err));
         chk("rdata", bus.rdata, e.rdata);
      end
      if (!keep_req) begin
         @(negedge HCLK);
         bus.req = 1'b0;
         @(posedge HCLK); #1;
         chk("ack_pulse", 32'(bus.ack), 32'd0);
         chk("htrans_idle_after", 32'(bus.HTRANS), 32'd0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ac, nf, nc, us, hb, acc0, nack;
      for (int i = 0; i < 64; i++) begin
         smem[i] = '0; ref_mem[i] = '0;
      end
      HRESET = 1'b1;
      bus.req = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
      bus.req_addr = '0; bus.req_wdata = '0;
      @(posedge HCLK); #1;
      chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("rst_haddr", bus.HADDR, 32'd0);
      chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
      chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
      chk("rst_hwdata", bus.HWDATA, 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("hburst", 32'(bus.HBURST), 32'd0);
      chk("hprot", 32'(bus.HPROT), 32'h3);
      chk("hmastlock", 32'(bus.HMASTLOCK), 32'd0);
      @(negedge HCLK);
      HRESET = 1'b0;

      // word write, 1 data wait state
      data_waits = 1;
      xfer(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, ac, nf, nc, us, hb);
      chk("wr_nonseq_cyc", 32'(nf), 32'd1);
      chk("wr_ack_cyc", 32'(ac), 32'd4);
      chk("wr_hwdata_hold", 32'(hb), 32'd0);
      chk("wr_mem", smem[4], 32'hDEADBEEF);

      // word read back, no waits
      data_waits = 0;
      xfer(1'b0, 2'd2, 32'h10, 32'h0, 0, ac, nf, nc, us, hb);
      chk("rd_ack_cyc", 32'(ac), 32'd3);
      chk("rd_nonseq_cnt", 32'(nc), 32'd1);

      // 5 address-phase wait states
      addr_waits = 5;
      acc0 = accepts;
      xfer(1'b1, 2'd2, 32'h20, 32'h12345678, 0, ac, nf, nc, us, hb);
      chk("aw_nonseq_cycles", 32'(nc), 32'd6);
      chk("aw_stable", 32'(us), 32'd0);
      chk("aw_accepts", 32'(accepts - acc0), 32'd1);
      addr_waits = 0;
      xfer(1'b0, 2'd2, 32'h20, 32'h0, 0, ac, nf, nc, us, hb);

      // misaligned and aligned sub-word requests
      acc0 = accepts;
      xfer(1'b1, 2'd1, 32'h3, 32'h1111, 0, ac, nf, nc, us, hb);
      chk("mis_hw_ack_cyc", 32'(ac), 32'd1);
      chk("mis_hw_no_bus", 32'(nc), 32'd0);
      xfer(1'b0, 2'd3, 32'h0, 32'h0, 0, ac, nf, nc, us, hb);
      chk("mis_sz3_no_bus", 32'(nc), 32'd0);
      xfer(1'b0, 2'd2, 32'h22, 32'h0, 0, ac, nf, nc, us, hb);
      chk("mis_word_no_bus", 32'(nc), 32'd0);
      chk("mis_accepts", 32'(accepts - acc0), 32'd0);
      xfer(1'b1, 2'd1, 32'h2A, 32'hCAFE0042, 0, ac, nf, nc, us, hb);
      chk("hw_ok_nonseq", 32'(nc), 32'd1);
      xfer(1'b0, 2'd0, 32'h2B, 32'h0, 0, ac, nf, nc, us, hb);
      chk("byte_ok_nonseq", 32'(nc), 32'd1);

      // back-to-back with req held across the ack cycle
      acc0 = accepts;
      xfer(1'b1, 2'd2, 32'h30, 32'hA5A55A5A, 1, ac, nf, nc, us, hb);
      xfer(1'b0, 2'd2, 32'h30, 32'h0, 0, ac, nf, nc, us, hb);
      chk("b2b_nonseq_cyc", 32'(nf), 32'd2);
      chk("b2b_accepts", 32'(accepts - acc0), 32'd2);

      // slave ERROR response on a write
      err_inject = 1;
      xfer(1'b1, 2'd2, 32'h40, 32'h00000BAD, 0, ac, nf, nc, us, hb);
      chk("errresp_ack_cyc", 32'(ac), 32'd4);
      err_inject = 0;

      // reset while in the data phase
      data_waits = 4;
      @(negedge HCLK);
      bus.req = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
      bus.req_addr = 32'h10;
      @(posedge HCLK); #1;
      chk("mid_nonseq", 32'(bus.HTRANS), 32'h2);
      @(posedge HCLK); #2;
      HRESET = 1'b1;
      #1;
      chk("mid_rst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("mid_rst_haddr", bus.HADDR, 32'd0);
      chk("mid_rst_hwrite", 32'(bus.HWRITE), 32'd0);
      chk("mid_rst_hsize", 32'(bus.HSIZE), 32'd0);
      chk("mid_rst_rdata", bus.rdata, 32'd0);
      chk("mid_rst_ack", 32'(bus.ack), 32'd0);
      bus.req = 1'b0;
      last_rdata = '0;
      nack = 0;
      @(negedge HCLK);
      HRESET = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge HCLK); #1;
         if (bus.ack === 1'b1) nack++;
      end
      chk("mid_rst_no_ack", 32'(nack), 32'd0);

      // recovery after reset
      data_waits = 0;
      xfer(1'b0, 2'd2, 32'h10, 32'h0, 0, ac, nf, nc, us, hb);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
